// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that owns the select lines of a 4:1 mux, with a per-grant
// hold limit so a busy requester cannot starve the others. Includes the mux itself.

module mux4_1 (
    input  logic i0,
    input  logic i1,
    input  logic i2,
    input  logic i3,
    input  logic s1,
    input  logic s0,
    output logic out
);
    always_comb begin
        case ({s1, s0})
            2'b00:   out = i0;
            2'b01:   out = i1;
            2'b10:   out = i2;
            default: out = i3;
        endcase
    end
endmodule

module mux4_rr_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s1,
    output logic       s0,
    output logic       valid
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] last_q, last_d;
    logic [7:0] hold_cnt, hold_d;

    logic [2:0] pick_all;
    logic [2:0] pick_others;
    logic [3:0] req_others;
    logic       release_now;

    // Returns {found, index}; search runs base+1, base+2, base+3, base (mod 4).
    // Iterating from the far end lets the nearest match overwrite the result.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        rr_pick = 3'b000;
        for (int k = 4; k >= 1; k--) begin
            idx = base + 2'(k);
            if (r[idx]) rr_pick = {1'b1, idx};
        end
    endfunction

    assign req_others  = req & ~(4'b0001 << owner_q);
    assign pick_all    = rr_pick(req, last_q);
    assign pick_others = rr_pick(req_others, last_q);
    assign release_now = !req[owner_q] || (hold_cnt == 8'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 4'b0000;
            sel_q    <= 2'b00;
            owner_q  <= 2'd0;
            last_q   <= 2'd3;
            hold_cnt <= 8'd0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            sel_q    <= sel_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            hold_cnt <= hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_cnt;
        case (state_q)
            IDLE: begin
                if (pick_all[2]) begin
                    state_d = GRANT;
                    gnt_d   = 4'b0001 << pick_all[1:0];
                    sel_d   = pick_all[1:0];
                    owner_d = pick_all[1:0];
                    last_d  = pick_all[1:0];
                    hold_d  = 8'd0;
                end
            end
            GRANT: begin
                if (!release_now) begin
                    hold_d = hold_cnt + 8'd1;
                end else if (pick_others[2]) begin
                    gnt_d   = 4'b0001 << pick_others[1:0];
                    sel_d   = pick_others[1:0];
                    owner_d = pick_others[1:0];
                    last_d  = pick_others[1:0];
                    hold_d  = 8'd0;
                end else if (req[owner_q]) begin
                    // Sole requester hit the hold limit: re-grant it in place.
                    hold_d = 8'd0;
                end else begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    hold_d  = 8'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt        = gnt_q;
    assign {s1, s0}   = sel_q;
    assign valid      = |gnt_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter driving a mux4_1; expected grant/select per
// cycle goes into a queue when stimulus is driven and is compared after the edge.

module tb_mux4_rr_arbiter;
    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       s1;
    logic       s0;
    logic       valid;
    logic [3:0] din;
    logic       mux_out;

    int passes = 0;
    int checks = 0;

    logic [5:0] exp_q[$];

    mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .gnt   (gnt),
        .s1    (s1),
        .s0    (s0),
        .valid (valid)
    );

    mux4_1 u_mux (
        .i0  (din[0]),
        .i1  (din[1]),
        .i2  (din[2]),
        .i3  (din[3]),
        .s1  (s1),
        .s0  (s0),
        .out (mux_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_outputs(input string tag, input logic [3:0] eg, input logic [1:0] es);
        checks++;
        assert (gnt === eg) passes++;
        else $error("FAIL %s gnt: observed %b expected %b", tag, gnt, eg);
        checks++;
        assert ({s1, s0} === es) passes++;
        else $error("FAIL %s sel: observed %b expected %b", tag, {s1, s0}, es);
        checks++;
        assert (valid === (eg != 4'b0000)) passes++;
        else $error("FAIL %s valid: observed %b expected %b", tag, valid, (eg != 4'b0000));
    endtask

    // Drive req (and random mux data), push the expectation, clock once, pop and compare.
    task automatic cyc(input string tag, input logic [3:0] r, input logic [3:0] eg,
                       input logic [1:0] es);
        logic [5:0] e;
        req = r;
        din = 4'($urandom_range(0, 15));
        exp_q.push_back({eg, es});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_outputs(tag, e[5:2], e[1:0]);
        checks++;
        assert (mux_out === din[e[1:0]]) passes++;
        else $error("FAIL %s mux_out: observed %b expected %b", tag, mux_out, din[e[1:0]]);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        din   = 4'b0001;
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", 4'b0000, 2'b00);
        rst_n = 1'b1;

        // Reset mid-grant: outputs clear immediately, then req[0] has priority.
        cyc("rst_mid_g1", 4'b0010, 4'b0010, 2'b01);
        cyc("rst_mid_g2", 4'b0010, 4'b0010, 2'b01);
        #3 rst_n = 1'b0;
        #1 check_outputs("async_reset", 4'b0000, 2'b00);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fairness with all requesting: 8-cycle grants 0,1,2,3,0 with no gap.
        cyc("after_reset", 4'b1111, 4'b0001, 2'b00);
        for (int c = 1; c < 8; c++) cyc("rr_0", 4'b1111, 4'b0001, 2'b00);
        for (int k = 1; k <= 4; k++)
            for (int c = 0; c < 8; c++)
                cyc("rr", 4'b1111, 4'b0001 << (k % 4), 2'(k % 4));
        cyc("rr_idle", 4'b0000, 4'b0000, 2'b00);

        // Single requester, then idle with select held.
        for (int c = 0; c < 3; c++) cyc("single", 4'b0100, 4'b0100, 2'b10);
        for (int c = 0; c < 2; c++) cyc("single_idle", 4'b0000, 4'b0000, 2'b10);

        // Early release and same-edge handover.
        cyc("early_0a", 4'b0011, 4'b0001, 2'b00);
        cyc("early_0b", 4'b0011, 4'b0001, 2'b00);
        cyc("handover", 4'b0010, 4'b0010, 2'b01);
        cyc("handover2", 4'b0010, 4'b0010, 2'b01);
        cyc("early_idle", 4'b0000, 4'b0000, 2'b01);

        // Sole requester across hold expiry: continuous grant, counter wraps at 7.
        for (int c = 0; c < 20; c++) begin
            cyc("sole", 4'b1000, 4'b1000, 2'b11);
            checks++;
            assert (dut.hold_cnt === 8'(c % 8)) passes++;
            else $error("FAIL sole hold_cnt: observed %0d expected %0d", dut.hold_cnt, c % 8);
        end
        cyc("sole_idle", 4'b0000, 4'b0000, 2'b11);

        // Mux integration with random data: from last=3, grant 0 then 1.
        for (int c = 0; c < 8; c++) cyc("mux_0", 4'b1111, 4'b0001, 2'b00);
        for (int c = 0; c < 8; c++) cyc("mux_1", 4'b1111, 4'b0010, 2'b01);
        cyc("mux_handover", 4'b1111, 4'b0100, 2'b10);
        cyc("final_idle", 4'b0000, 4'b0000, 2'b10);

        checks++;
        assert (exp_q.size() == 0) passes++;
        else $error("FAIL queue_empty: observed %0d expected 0", exp_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
